fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Controls the in-place radix-2 decimation-in-time butterfly datapath of the 256-point FFT. It starts when the input buffer signals that a bit-reversed frame is fully loaded (`flush`). It then issues butterfly read-address pairs and twiddle indices for all LOG2N stages, and tracks write-backs through the butterfly pipeline. Between stages it drains the pipeline, so that every stage-s result is written before any stage-(s+1) read is issued.

## Interface
- `LOG2N`, 8, log2 of transform size; N = 2^LOG2N, N/2 butterflies per stage.
- `BF_LATENCY`, 3, cycles from butterfly issue to write-back (legal range 1..15).
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `flush`  in  1  frame-loaded pulse from input buffer.
- `bf_ready`  in  1  butterfly datapath accepts an issue this cycle.
- `bf_valid`  out  1  issue valid; transfer = `bf_valid && bf_ready`.
- `addr_a`  out  LOG2N  upper-leg address.
- `addr_b`  out  LOG2N  lower-leg address.
- `tw_idx`  out  LOG2N-1  twiddle index into W_N^k ROM.
- `stage`  out  3  current stage, 0..LOG2N-1.
- `wb_valid`  out  1  write-back strobe for results at `wb_addr_a`/`wb_addr_b`.
- `wb_addr_a`, `wb_addr_b`  out  LOG2N each  write-back addresses.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle pulse, transform complete.
- `overrun`  out  1  sticky; present only with FFT_SEQ_OVERRUN_EN.

## Operation
- States:
  - IDLE: waits for `flush`.
  - ISSUE: issues butterflies.
  - DRAIN: waits for the write-back pipeline to empty.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE/DONE + `flush` -> ISSUE, with stage=0 and k=0.
  - DONE without `flush` -> IDLE.
  - ISSUE, on the transfer with k=N/2-1 -> DRAIN.
  - DRAIN -> ISSUE (stage+1, k=0) in the cycle after the last in-flight write-back. If stage=LOG2N-1, go to DONE instead.
- Butterfly counter k (LOG2N-1 bits) increments only on a transfer. `bf_ready`=0 holds k, the addresses and `bf_valid`.
- Address generation for stage s, span = 2^s:
  - pos = k mod span; group = k >> s.
  - `addr_a` = group·2^(s+1) + pos.
  - `addr_b` = `addr_a` + span.
  - `tw_idx` = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
- `bf_valid` = (state==ISSUE). Addresses are derived from registered k and stage. Outside ISSUE, addresses and `tw_idx` read 0.
- Write-back pipeline:
  - A BF_LATENCY-deep shift register carries {valid, addr_a, addr_b}, loaded on each transfer.
  - It advances every cycle and is unaffected by `bf_ready`.
- `flush` is ignored in ISSUE and DRAIN; the frame in progress is unaffected.
- `stage` holds its value through DRAIN and resets to 0 on entering IDLE.

## Timing
- Reset: state=IDLE. All outputs 0: `bf_valid`, `wb_valid`, `busy`, `done`, `overrun`, `stage`, all addresses and `tw_idx`. The write-back pipeline is cleared.
- Reset mid-frame: the next cycle is IDLE with all outputs 0. No further `wb_valid` pulses occur for that frame.
- `flush` sampled high at edge t -> `bf_valid`=1 in cycle t+1 (call it cycle 0).
- A transfer in cycle c -> `wb_valid` with the same addresses in cycle c+BF_LATENCY.
- Last transfer of a stage at cycle c:
  - DRAIN covers cycles c+1..c+BF_LATENCY.
  - The next stage's first issue is at c+BF_LATENCY+1.
- With `bf_ready` held high:
  - Each stage takes N/2+BF_LATENCY cycles.
  - `done` is high in cycle LOG2N·(N/2+BF_LATENCY) relative to cycle 0; for defaults this is cycle 1048.
- `flush` in the DONE cycle starts the next frame with no IDLE cycle in between. `done` still pulses.
- Stalls in ISSUE extend only that stage. No butterfly is skipped or duplicated.

## Configuration
- `FFT_SEQ_OVERRUN_EN` defined:
  - `overrun` is set in the cycle after `flush` is sampled high while `busy`=1.
  - It stays 1 until `reset`.
- Not defined: the `overrun` port is absent and `flush` during `busy` is silently ignored.

## Test plan
- Single frame, `bf_ready`=1, defaults: `flush` pulse -> exactly 1024 transfers and 1024 `wb_valid`. `done` pulses once at cycle 1048; `busy` is low afterwards.
- Address spot-checks:
  - stage 0, k=5 -> a=10, b=11, tw=0.
  - stage 3, k=13 -> a=21, b=29, tw=80.
  - stage 7, k=5 -> a=5, b=133, tw=5.
- Random `bf_ready` stalls (30% low): the set of {stage, addr_a, addr_b, tw_idx} issues is identical to the no-stall run. Each `wb_valid` occurs exactly 3 cycles after its transfer. No stage-s+1 issue happens before the last stage-s write-back.
- Reset asserted at cycle 500: the next cycle shows all outputs 0 and no later `wb_valid`. A new `flush` restarts at stage 0, k=0.
- `flush` pulsed at cycle 200 during a frame: the frame completes unchanged. With FFT_SEQ_OVERRUN_EN, `overrun`=1 from cycle 201 until reset.
- `flush` in the DONE cycle: `bf_valid`=1 next cycle with stage=0, a=0, b=1.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_sequencer_if
//  Description : Handshake and address bus between the FFT stage sequencer,
//                the input buffer and the butterfly datapath. The overrun
//                flag exists only when FFT_SEQ_OVERRUN_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_stage_sequencer_if #(
    parameter int LOG2N = 8
);
    logic             flush;
    logic             bf_ready;
    logic             bf_valid;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [2:0]       stage;
    logic             wb_valid;
    logic [LOG2N-1:0] wb_addr_a;
    logic [LOG2N-1:0] wb_addr_b;
    logic             busy;
    logic             done;
`ifdef FFT_SEQ_OVERRUN_EN
    logic             overrun;

    modport master (
        input  flush, bf_ready,
        output bf_valid, addr_a, addr_b, tw_idx, stage,
               wb_valid, wb_addr_a, wb_addr_b, busy, done, overrun
    );
    modport slave (
        output flush, bf_ready,
        input  bf_valid, addr_a, addr_b, tw_idx, stage,
               wb_valid, wb_addr_a, wb_addr_b, busy, done, overrun
    );
`else
    modport master (
        input  flush, bf_ready,
        output bf_valid, addr_a, addr_b, tw_idx, stage,
               wb_valid, wb_addr_a, wb_addr_b, busy, done
    );
    modport slave (
        output flush, bf_ready,
        input  bf_valid, addr_a, addr_b, tw_idx, stage,
               wb_valid, wb_addr_a, wb_addr_b, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_sequencer
//  Description : Issue/drain sequencer for the in-place radix-2 DIT FFT.
//                Optional sticky overrun flag under FFT_SEQ_OVERRUN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter int LOG2N      = 8,
    parameter int BF_LATENCY = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    fft_stage_sequencer_if.master  bus
);
    localparam int         c_KW      = LOG2N - 1;
    localparam logic [c_KW-1:0] c_K_LAST = {c_KW{1'b1}};
    localparam logic [2:0] c_S_LAST  = 3'(LOG2N - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_stage;
    logic [2:0]       w_stage_nxt;
    logic [c_KW-1:0]  r_k;
    logic [c_KW-1:0]  w_k_nxt;

    logic             w_issue;
    logic             w_busy;
    logic             w_xfer;
    logic             w_inflight;

    logic [LOG2N-1:0] w_k_ext;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_group;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [LOG2N-1:0] w_tw_full;
    logic [3:0]       w_tw_shift;

    logic             r_pipe_v [BF_LATENCY];
    logic [LOG2N-1:0] r_pipe_a [BF_LATENCY];
    logic [LOG2N-1:0] r_pipe_b [BF_LATENCY];

    assign w_issue = (r_state == c_ST_ISSUE);
    assign w_busy  = w_issue || (r_state == c_ST_DRAIN);
    assign w_xfer  = w_issue && bus.bf_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_stage <= 3'd0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_k_nxt     = r_k;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = c_ST_ISSUE;
                    w_stage_nxt = 3'd0;
                    w_k_nxt     = '0;
                end
            end
            c_ST_ISSUE: begin
                if (w_xfer) begin
                    w_k_nxt = r_k + 1'b1;
                    if (r_k == c_K_LAST) begin
                        w_state_nxt = c_ST_DRAIN;
                        w_k_nxt     = '0;
                    end
                end
            end
            c_ST_DRAIN: begin
                // Leave once only the final stage of the pipe can still hold data.
                if (!w_inflight) begin
                    if (r_stage == c_S_LAST) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_ISSUE;
                        w_stage_nxt = r_stage + 3'd1;
                        w_k_nxt     = '0;
                    end
                end
            end
            c_ST_DONE: begin
                w_stage_nxt = 3'd0;
                w_k_nxt     = '0;
                w_state_nxt = bus.flush ? c_ST_ISSUE : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_stage_nxt = 3'd0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Split k into (group, pos) around bit 'stage' and insert a zero there.
    always_comb begin
        w_k_ext    = {1'b0, r_k};
        w_span     = {{(LOG2N-1){1'b0}}, 1'b1} << r_stage;
        w_pos      = w_k_ext & (w_span - 1'b1);
        w_group    = w_k_ext >> r_stage;
        w_addr_a   = (w_group << ({1'b0, r_stage} + 4'd1)) | w_pos;
        w_addr_b   = w_addr_a + w_span;
        w_tw_shift = 4'(c_KW) - {1'b0, r_stage};
        w_tw_full  = w_pos << w_tw_shift;
    end

    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < BF_LATENCY - 1; i++) begin
            w_inflight = w_inflight | r_pipe_v[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                r_pipe_v[i] <= 1'b0;
                r_pipe_a[i] <= '0;
                r_pipe_b[i] <= '0;
            end
        end else begin
            r_pipe_v[0] <= w_xfer;
            r_pipe_a[0] <= w_xfer ? w_addr_a : '0;
            r_pipe_b[0] <= w_xfer ? w_addr_b : '0;
            for (int i = 1; i < BF_LATENCY; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_a[i] <= r_pipe_a[i-1];
                r_pipe_b[i] <= r_pipe_b[i-1];
            end
        end
    end

    assign bus.bf_valid  = w_issue;
    assign bus.addr_a    = w_issue ? w_addr_a : '0;
    assign bus.addr_b    = w_issue ? w_addr_b : '0;
    assign bus.tw_idx    = w_issue ? w_tw_full[LOG2N-2:0] : '0;
    assign bus.stage     = r_stage;
    assign bus.wb_valid  = r_pipe_v[BF_LATENCY-1];
    assign bus.wb_addr_a = r_pipe_a[BF_LATENCY-1];
    assign bus.wb_addr_b = r_pipe_b[BF_LATENCY-1];
    assign bus.busy      = w_busy;
    assign bus.done      = (r_state == c_ST_DONE);

`ifdef FFT_SEQ_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (bus.flush && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign bus.overrun = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_stage_sequencer
//  Description : Self-checking bench for fft_stage_sequencer (address table,
//                randomized stalls, mid-frame reset, flush corner cases).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_stage_sequencer;
    localparam int LOG2N = 8;
    localparam int HALF  = 128;
    localparam int L     = 3;
    localparam int TOTAL = LOG2N * HALF;

    logic clk = 1'b0;
    logic reset;

    fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_stage_sequencer #(
        .LOG2N      (LOG2N),
        .BF_LATENCY (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } vec_t;

    vec_t tbl [7];

    int m_stage [TOTAL];
    int m_a     [TOTAL];
    int m_b     [TOTAL];
    int m_tw    [TOTAL];
    int cap_stage [TOTAL];
    int cap_a     [TOTAL];
    int cap_b     [TOTAL];
    int cap_tw    [TOTAL];

    int n_chk  = 0;
    int n_pass = 0;

    int xfers, wbs, done_cyc, done_cnt;
    int e_seq, e_wb, e_order, e_idle, e_ovr;
    bit timed_out;
    bit ovr_exp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference issue order: stage, then group, then position inside the group.
    function automatic void build_model();
        int idx;
        int span;
        idx = 0;
        for (int s = 0; s < LOG2N; s++) begin
            span = 1 << s;
            for (int g = 0; g < HALF / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    m_stage[idx] = s;
                    m_a[idx]     = g * 2 * span + p;
                    m_b[idx]     = m_a[idx] + span;
                    m_tw[idx]    = p * (HALF / span);
                    idx++;
                end
            end
        end
    endfunction

    task automatic run_frame(input int stall_pct, input int reset_at,
                             input int flush_at, input bit chain);
        int q_cyc [$];
        int q_a   [$];
        int q_b   [$];
        int idx, prev_stage, ec, ea, eb;
        bit fin;
        xfers = 0; wbs = 0; done_cyc = -1; done_cnt = 0;
        e_seq = 0; e_wb = 0; e_order = 0; e_idle = 0; e_ovr = 0;
        timed_out = 1'b0;
        idx = 0; prev_stage = 0; fin = 1'b0;
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.bf_ready = 1'b1;
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            @(negedge clk);
            bus.flush    = (cyc == flush_at);
            bus.bf_ready = ($urandom_range(99) >= stall_pct);
            reset        = (cyc == reset_at);
            if (bus.wb_valid) begin
                wbs++;
                if (q_cyc.size() == 0) begin
                    e_wb++;
                end else begin
                    ec = q_cyc.pop_front();
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    if (ec != cyc || ea != int'(bus.wb_addr_a) || eb != int'(bus.wb_addr_b)) e_wb++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (bus.busy) e_idle++;
            end
            if (bus.bf_valid) begin
                if (!bus.busy) e_idle++;
                if (bus.bf_ready) begin
                    if (idx >= TOTAL) begin
                        e_seq++;
                    end else begin
                        if (int'(bus.stage) != m_stage[idx] || int'(bus.addr_a) != m_a[idx] ||
                            int'(bus.addr_b) != m_b[idx] || int'(bus.tw_idx) != m_tw[idx]) e_seq++;
                        if (int'(bus.stage) != prev_stage && q_cyc.size() != 0) e_order++;
                        cap_stage[idx] = int'(bus.stage);
                        cap_a[idx]     = int'(bus.addr_a);
                        cap_b[idx]     = int'(bus.addr_b);
                        cap_tw[idx]    = int'(bus.tw_idx);
                        prev_stage     = int'(bus.stage);
                    end
                    q_cyc.push_back(cyc + L);
                    q_a.push_back(int'(bus.addr_a));
                    q_b.push_back(int'(bus.addr_b));
                    idx++;
                    xfers++;
                end
            end else if (bus.addr_a != '0 || bus.addr_b != '0 || bus.tw_idx != '0) begin
                e_idle++;
            end
`ifdef FFT_SEQ_OVERRUN_EN
            if (bus.overrun !== ovr_exp) e_ovr++;
            if (cyc == flush_at) ovr_exp = 1'b1;
`endif
            if (cyc == reset_at) fin = 1'b1;
            if (bus.done) begin
                fin = 1'b1;
                if (chain) bus.flush = 1'b1;
            end
            if (cyc == 4999 && !fin) timed_out = 1'b1;
        end
    endtask

    int idx_t;
    int wb_late;

    initial begin
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.bf_ready = 1'b0;
        build_model();
        tbl[0] = '{s: 0, k: 5,   a: 10,  b: 11,  tw: 0};
        tbl[1] = '{s: 3, k: 13,  a: 21,  b: 29,  tw: 80};
        tbl[2] = '{s: 7, k: 5,   a: 5,   b: 133, tw: 5};
        tbl[3] = '{s: 0, k: 0,   a: 0,   b: 1,   tw: 0};
        tbl[4] = '{s: 7, k: 127, a: 127, b: 255, tw: 127};
        tbl[5] = '{s: 1, k: 3,   a: 5,   b: 7,   tw: 64};
        tbl[6] = '{s: 6, k: 70,  a: 134, b: 198, tw: 12};

        repeat (3) @(negedge clk);
        check("rst_bf_valid", int'(bus.bf_valid), 0);
        check("rst_wb_valid", int'(bus.wb_valid), 0);
        check("rst_busy",     int'(bus.busy), 0);
        check("rst_done",     int'(bus.done), 0);
        check("rst_stage",    int'(bus.stage), 0);
        check("rst_addr_a",   int'(bus.addr_a), 0);
        check("rst_addr_b",   int'(bus.addr_b), 0);
        check("rst_tw_idx",   int'(bus.tw_idx), 0);
`ifdef FFT_SEQ_OVERRUN_EN
        check("rst_overrun",  int'(bus.overrun), 0);
`endif
        reset = 1'b0;

        // Full frame with the datapath always ready.
        run_frame(0, -1, -1, 1'b0);
        check("t1_timeout",   int'(timed_out), 0);
        check("t1_transfers", xfers, TOTAL);
        check("t1_wb_count",  wbs, TOTAL);
        check("t1_done_cyc",  done_cyc, 1048);
        check("t1_done_cnt",  done_cnt, 1);
        check("t1_seq_err",   e_seq, 0);
        check("t1_wb_err",    e_wb, 0);
        check("t1_order_err", e_order, 0);
        check("t1_idle_err",  e_idle, 0);
        @(negedge clk);
        check("t1_busy_after", int'(bus.busy), 0);
        check("t1_done_after", int'(bus.done), 0);
        for (int i = 0; i < 7; i++) begin
            idx_t = tbl[i].s * HALF + tbl[i].k;
            check($sformatf("tbl%0d_stage", i), cap_stage[idx_t], tbl[i].s);
            check($sformatf("tbl%0d_addr_a", i), cap_a[idx_t], tbl[i].a);
            check($sformatf("tbl%0d_addr_b", i), cap_b[idx_t], tbl[i].b);
            check($sformatf("tbl%0d_tw_idx", i), cap_tw[idx_t], tbl[i].tw);
        end

        // Random back-pressure, 30% of cycles not ready.
        run_frame(30, -1, -1, 1'b0);
        check("t2_timeout",   int'(timed_out), 0);
        check("t2_transfers", xfers, TOTAL);
        check("t2_wb_count",  wbs, TOTAL);
        check("t2_seq_err",   e_seq, 0);
        check("t2_wb_err",    e_wb, 0);
        check("t2_order_err", e_order, 0);
        check("t2_idle_err",  e_idle, 0);
        check("t2_done_cnt",  done_cnt, 1);
        check("t2_done_late", int'(done_cyc > 1048), 1);
        @(negedge clk);

        // Reset in the middle of a frame.
        run_frame(0, 500, -1, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        ovr_exp = 1'b0;
        check("t3_bf_valid", int'(bus.bf_valid), 0);
        check("t3_wb_valid", int'(bus.wb_valid), 0);
        check("t3_busy",     int'(bus.busy), 0);
        check("t3_done",     int'(bus.done), 0);
        check("t3_stage",    int'(bus.stage), 0);
        check("t3_addrs",    int'(bus.addr_a) + int'(bus.addr_b) + int'(bus.tw_idx), 0);
        wb_late = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wb_valid) wb_late++;
        end
        check("t3_no_late_wb", wb_late, 0);
        run_frame(0, -1, -1, 1'b0);
        check("t3_restart_seq", e_seq, 0);
        check("t3_restart_done", done_cyc, 1048);
        @(negedge clk);

        // Stray flush while busy must not disturb the frame.
        run_frame(0, -1, 200, 1'b0);
        check("t4_transfers", xfers, TOTAL);
        check("t4_seq_err",   e_seq, 0);
        check("t4_done_cyc",  done_cyc, 1048);
        check("t4_wb_err",    e_wb, 0);
        check("t4_ovr_err",   e_ovr, 0);
        @(negedge clk);

        // Flush in the DONE cycle restarts immediately.
        run_frame(0, -1, -1, 1'b1);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_ovr_err",  e_ovr, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        check("t5_bf_valid", int'(bus.bf_valid), 1);
        check("t5_stage",    int'(bus.stage), 0);
        check("t5_addr_a",   int'(bus.addr_a), 0);
        check("t5_addr_b",   int'(bus.addr_b), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
